// File: rtl/m_telemetry_serializer.sv
// Telemetry phrase serializer: pair-encodes buffer words, overlays frame markers,
// shifts them out MSB-first at clk/BIT_DIV, and keeps a BCD seconds count.

module m_tlm_pair_enc (
  input  logic       d_i,
  input  logic       man_i,
  output logic [1:0] pair_o
);
  assign pair_o = {d_i, d_i ^ man_i};
endmodule

module m_telemetry_serializer #(
  parameter int DATA_W      = 12,
  parameter int BIT_DIV     = 4,
  parameter int ADDR_W      = 7,
  parameter int PHR_PER_GRP = 128,
  parameter int GRP_PER_CCL = 32,
  parameter int CCL_PER_SEC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iEn,
  input  logic              iMode,
  input  logic [DATA_W-1:0] iData,
  output logic              oRdEn,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oSwitch,
  output logic              oSerial,
  output logic [DATA_W-1:0] oParallel,
  output logic              oValid,
  output logic              oFrameStart,
  output logic [15:0]       oSec
);
  localparam int WW = 2 * DATA_W;
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int BW = $clog2(WW);
  localparam int PW = $clog2(PHR_PER_GRP);
  localparam int GW = (GRP_PER_CCL > 1) ? $clog2(GRP_PER_CCL) : 1;
  localparam int CW = (CCL_PER_SEC > 1) ? $clog2(CCL_PER_SEC) : 1;

  logic [DW-1:0]     div_q;
  logic [BW-1:0]     bit_q;
  logic [PW-1:0]     phr_q, phr_d;
  logic [GW-1:0]     grp_q, grp_d;
  logic [CW-1:0]     ccl_q, ccl_d;
  logic [ADDR_W-1:0] addr_q;
  logic              run_q;
  logic [WW-1:0]     word_q;

  logic                   last_div, last_bit, sec_tick, sec_cy;
  logic [BW-1:0]          bit_idx;
  logic [15:0]            sec_d;
  logic [1:0]             mk;
  logic [DATA_W-1:0]      par;
  logic [DATA_W-1:0][1:0] enc_pairs;
  logic [WW-1:0]          enc_word;

  assign last_div = (div_q == DW'(BIT_DIV - 1));
  assign last_bit = (bit_q == BW'(WW - 1));
  assign bit_idx  = BW'(WW - 1) - bit_q;

  for (genvar i = 0; i < DATA_W; i++) begin : g_enc
    m_tlm_pair_enc u_enc (
      .d_i   (iData[i]),
      .man_i (iMode),
      .pair_o(enc_pairs[i])
    );
  end
  assign enc_word = enc_pairs;

  always_comb begin
    par = '0;
    for (int i = 0; i < DATA_W; i++) par[i] = word_q[2*i+1];
  end

  // Phrase -> group -> cycle -> seconds carry chain, evaluated for the next word.
  always_comb begin
    phr_d    = phr_q;
    grp_d    = grp_q;
    ccl_d    = ccl_q;
    sec_tick = 1'b0;
    if (phr_q == PW'(PHR_PER_GRP - 1)) begin
      phr_d = '0;
      if (grp_q == GW'(GRP_PER_CCL - 1)) begin
        grp_d = '0;
        if (ccl_q == CW'(CCL_PER_SEC - 1)) begin
          ccl_d    = '0;
          sec_tick = 1'b1;
        end else begin
          ccl_d = ccl_q + 1'b1;
        end
      end else begin
        grp_d = grp_q + 1'b1;
      end
    end else begin
      phr_d = phr_q + 1'b1;
    end
  end

  always_comb begin
    sec_d  = oSec;
    sec_cy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (sec_cy) begin
        if (oSec[4*i +: 4] == 4'd9) begin
          sec_d[4*i +: 4] = 4'd0;
        end else begin
          sec_d[4*i +: 4] = oSec[4*i +: 4] + 4'd1;
          sec_cy          = 1'b0;
        end
      end
    end
  end

  // Markers follow the counters of the word being loaded, not the one on the line.
  always_comb begin
    mk = {~phr_d[0], 1'b0};
    if (grp_d == GW'(GRP_PER_CCL - 1)) begin
      if (phr_d == PW'(PHR_PER_GRP - 15) || phr_d == PW'(PHR_PER_GRP - 7) ||
          phr_d == PW'(PHR_PER_GRP - 5)  || phr_d == PW'(PHR_PER_GRP - 1))
        mk = 2'b11;
    end else begin
      if (phr_d == PW'(PHR_PER_GRP - 13) || phr_d == PW'(PHR_PER_GRP - 11) ||
          phr_d == PW'(PHR_PER_GRP - 9)  || phr_d == PW'(PHR_PER_GRP - 3))
        mk = 2'b11;
    end
    if (ccl_d == '0 && grp_d == '0 && phr_d == PW'(15)) mk = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      bit_q       <= '0;
      phr_q       <= '0;
      grp_q       <= '0;
      ccl_q       <= '0;
      addr_q      <= '0;
      run_q       <= iEn;
      word_q      <= {1'b1, {(WW-1){1'b0}}};
      oSerial     <= 1'b0;
      oParallel   <= '0;
      oValid      <= 1'b0;
      oRdEn       <= 1'b0;
      oAddr       <= '0;
      oSwitch     <= 1'b0;
      oFrameStart <= 1'b0;
      oSec        <= '0;
    end else begin
      oValid      <= 1'b0;
      oRdEn       <= 1'b0;
      oFrameStart <= 1'b0;
      div_q       <= last_div ? '0 : div_q + 1'b1;
      if (last_div) bit_q <= last_bit ? '0 : bit_q + 1'b1;

      if (div_q == '0) begin
        oSerial <= run_q & word_q[bit_idx];
        if (run_q && bit_q == '0) begin
          oValid      <= 1'b1;
          oParallel   <= par;
          oFrameStart <= (phr_q == '0) && (grp_q == '0) && (ccl_q == '0);
        end
        if (run_q && last_bit) begin
          oRdEn  <= 1'b1;
          oAddr  <= addr_q;
          addr_q <= addr_q + 1'b1;
          if (addr_q == '1) oSwitch <= ~oSwitch;
        end
      end

      // Word boundary: a stalled or restarting word keeps counters and word register.
      if (last_div && last_bit) begin
        run_q <= iEn;
        if (iEn && run_q) begin
          phr_q  <= phr_d;
          grp_q  <= grp_d;
          ccl_q  <= ccl_d;
          word_q <= enc_word | {mk, {(WW-2){1'b0}}};
          if (sec_tick) oSec <= sec_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_m_telemetry_serializer.sv
// Randomized scoreboard bench for m_telemetry_serializer with a word-level reference model.

module tb_m_telemetry_serializer;
  localparam int DW   = 12;
  localparam int BD   = 3;
  localparam int AW   = 3;
  localparam int PP   = 16;
  localparam int GP   = 2;
  localparam int CP   = 2;
  localparam int WW   = 2 * DW;
  localparam int PER  = WW * BD;
  localparam int NPER = 900;

  logic          clk = 1'b0;
  logic          reset, iEn, iMode;
  logic [DW-1:0] iData;
  logic          oRdEn, oSwitch, oSerial, oValid, oFrameStart;
  logic [AW-1:0] oAddr;
  logic [DW-1:0] oParallel;
  logic [15:0]   oSec;

  m_telemetry_serializer #(
    .DATA_W(DW), .BIT_DIV(BD), .ADDR_W(AW),
    .PHR_PER_GRP(PP), .GRP_PER_CCL(GP), .CCL_PER_SEC(CP)
  ) dut (
    .clk(clk), .reset(reset), .iEn(iEn), .iMode(iMode), .iData(iData),
    .oRdEn(oRdEn), .oAddr(oAddr), .oSwitch(oSwitch), .oSerial(oSerial),
    .oParallel(oParallel), .oValid(oValid), .oFrameStart(oFrameStart), .oSec(oSec)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] word;
    logic [DW-1:0] par;
    logic          fs;
    logic [15:0]   sec;
  } wexp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          sw;
  } rexp_t;

  wexp_t         wq[$];
  rexp_t         rq[$];
  logic [DW-1:0] mem [2**AW];
  int            checks = 0;
  int            errors = 0;
  bit            sb_on  = 1'b0;
  bit            quiet  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s got=event want=none", nm);
  endtask

  function automatic logic [1:0] tb_mk(input int p, input int g, input int c);
    logic [1:0] r;
    r = (p % 2 == 0) ? 2'b10 : 2'b00;
    if (g == GP - 1) begin
      if (p == PP-15 || p == PP-7 || p == PP-5 || p == PP-1) r = 2'b11;
    end else if (p == PP-13 || p == PP-11 || p == PP-9 || p == PP-3) r = 2'b11;
    if (c == 0 && g == 0 && p == 15) r = 2'b11;
    return r;
  endfunction

  function automatic logic [WW-1:0] tb_enc(input logic [DW-1:0] d, input bit man);
    logic [WW-1:0] w;
    for (int i = 0; i < DW; i++) begin
      w[2*i+1] = d[i];
      w[2*i]   = man ? ~d[i] : d[i];
    end
    return w;
  endfunction

  function automatic logic [DW-1:0] tb_par(input logic [WW-1:0] w);
    logic [DW-1:0] p;
    for (int i = 0; i < DW; i++) p[i] = w[2*i+1];
    return p;
  endfunction

  function automatic logic [15:0] tb_bcd(input int s);
    return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_serial"}, oSerial, 0);
    chk({tag, "_par"},    oParallel, 0);
    chk({tag, "_valid"},  oValid, 0);
    chk({tag, "_rden"},   oRdEn, 0);
    chk({tag, "_addr"},   oAddr, 0);
    chk({tag, "_switch"}, oSwitch, 0);
    chk({tag, "_fs"},     oFrameStart, 0);
    chk({tag, "_sec"},    oSec, 0);
  endtask

  // Memory responds to a read strobe half a clock later.
  always @(negedge clk) if (oRdEn) iData = mem[oAddr];

  int            m_phr, m_grp, m_ccl, m_sec, m_addr;
  bit            m_run, m_sw;
  logic [WW-1:0] m_word;

  initial begin
    wexp_t         e;
    rexp_t         r;
    logic [DW-1:0] data;
    bit            en, mode, nsw;
    reset = 1'b1; iEn = 1'b1; iMode = 1'b0; iData = '0;
    foreach (mem[i]) mem[i] = DW'($urandom);
    repeat (3) @(negedge clk);
    check_reset("rst0");
    reset = 1'b0;
    repeat (1 + 10*BD) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    @(negedge clk);

    m_phr = 0; m_grp = 0; m_ccl = 0; m_sec = 0; m_addr = 0;
    m_run = 1'b1; m_sw = 1'b0; m_word = {1'b1, {(WW-1){1'b0}}};
    data = '0;
    reset = 1'b0;
    sb_on = 1'b1;
    for (int k = 0; k < NPER; k++) begin
      en   = ($urandom_range(15) != 0);
      mode = 1'($urandom_range(1));
      if (k >= 40 && k < 43) en = 1'b0;
      if (k == 43) en = 1'b1;
      if (k == NPER - 1) en = 1'b0;
      iEn = en; iMode = mode;
      quiet = !m_run;
      if (m_run) begin
        mem[AW'(m_addr)] = DW'($urandom);
        data   = mem[AW'(m_addr)];
        e.word = m_word;
        e.par  = tb_par(m_word);
        e.fs   = (m_phr == 0 && m_grp == 0 && m_ccl == 0);
        e.sec  = tb_bcd(m_sec);
        wq.push_back(e);
        nsw    = m_sw ^ (m_addr == 2**AW - 1);
        r.addr = AW'(m_addr);
        r.sw   = nsw;
        rq.push_back(r);
        m_sw   = nsw;
        m_addr = (m_addr + 1) % (2**AW);
      end
      if (!en) m_run = 1'b0;
      else if (!m_run) m_run = 1'b1;
      else begin
        m_phr++;
        if (m_phr == PP) begin
          m_phr = 0; m_grp++;
          if (m_grp == GP) begin
            m_grp = 0; m_ccl++;
            if (m_ccl == CP) begin m_ccl = 0; m_sec = (m_sec + 1) % 10000; end
          end
        end
        m_word = tb_enc(data, mode) | {tb_mk(m_phr, m_grp, m_ccl), {(WW-2){1'b0}}};
      end
      repeat (PER) @(negedge clk);
    end
    quiet = !m_run;
    repeat (2*PER) @(negedge clk);
    chk("words_drained", wq.size(), 0);
    chk("reads_drained", rq.size(), 0);
    chk("sec_final", oSec, tb_bcd(m_sec));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Word monitor: parallel tap, frame strobe, seconds and the full serial word.
  initial begin
    wexp_t         me;
    logic [WW-1:0] got;
    forever begin
      @(posedge clk); #1;
      if (sb_on && oValid) begin
        if (wq.size() == 0) fail_now("unexpected_word");
        else begin
          me = wq.pop_front();
          chk("parallel", oParallel, me.par);
          chk("frame_start", oFrameStart, me.fs);
          chk("seconds", oSec, me.sec);
          for (int b = 0; b < WW; b++) begin
            got[WW-1-b] = oSerial;
            if (b < WW - 1) begin
              repeat (BD) @(posedge clk); #1;
            end
          end
          chk("line_word", got, me.word);
        end
      end
    end
  end

  // Read monitor: address sequence, bank toggle, one-clock strobe width.
  initial begin
    rexp_t rr;
    logic  prev_rd = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sb_on && oRdEn) begin
        if (prev_rd) fail_now("rden_width");
        if (rq.size() == 0) fail_now("unexpected_read");
        else begin
          rr = rq.pop_front();
          chk("rd_addr", oAddr, rr.addr);
          chk("rd_switch", oSwitch, rr.sw);
        end
      end
      prev_rd = oRdEn;
    end
  end

  // Idle monitor: a stalled line stays low and silent.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (sb_on) begin
        if (oFrameStart && !oValid) fail_now("fs_without_valid");
        if (quiet) begin
          chk("idle_serial", oSerial, 0);
          chk("idle_valid", oValid, 0);
          chk("idle_rden", oRdEn, 0);
        end
      end
    end
  end
endmodule

// File: doc/m_telemetry_serializer.md
Name: m_telemetry_serializer

Overview:
- Parametrised successor of the M16 phrase serializer.
- Reads DATA_W-bit words from the shared telemetry buffer and pair-encodes each data bit (doubled or Manchester, chosen per word).
- Overlays phrase, group and cycle marker bits, then shifts the word out MSB-first at clk/BIT_DIV.
- Also provides a parallel word tap, bank-switch control, a 4-digit BCD seconds counter and a word-boundary enable.

Parameters:
- DATA_W, 12, data bits per word; line word width WW = 2*DATA_W.
- BIT_DIV, 4, clocks per line bit (>=3).
- ADDR_W, 7, buffer address width; the address counter wraps at 2^ADDR_W.
- PHR_PER_GRP, 128, phrases per group (even, >=16).
- GRP_PER_CCL, 32, groups per cycle.
- CCL_PER_SEC, 4, cycles per second tick.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- iEn  in  1  run enable, sampled only at word boundaries.
- iMode  in  1  encoding for the next word: 0 = doubled (d,d), 1 = Manchester (d,~d).
- iData  in  DATA_W  buffer read data.
- oRdEn  out  1  one-clock read strobe.
- oAddr  out  ADDR_W  buffer read address.
- oSwitch  out  1  bank select; toggles on address wrap.
- oSerial  out  1  serial line bit.
- oParallel  out  DATA_W  upper bit of each pair of the word on the line.
- oValid  out  1  one-clock strobe qualifying oParallel.
- oFrameStart  out  1  one-clock strobe at phrase 0, group 0, cycle 0.
- oSec  out  16  BCD seconds, 4 digits, 0000..9999.

Behaviour:
- Reset (synchronous, takes priority over everything, may arrive mid-word):
  - Outputs: oSerial=0, oParallel=0, oValid=0, oRdEn=0, oAddr=0, oSwitch=0, oFrameStart=0, oSec=0.
  - Counters: div d=0, bit b=0, phrase=0, group=0, cycle=0, address counter=0.
  - Word register = marker pattern for phrase 0 (bit WW-1 = 1, all others 0).
  - Block comes up running if iEn=1.
- Timing counters: d runs 0..BIT_DIV-1; b increments when d=BIT_DIV-1 and runs 0..WW-1.
- At d=0: oSerial <= word[WW-1-b] (MSB first).
  - If b=0 also: oValid<=1, oParallel<=word bits WW-1, WW-3, ... 1, and oFrameStart<=1 if phrase=group=cycle=0.
  - All strobes deassert on the next clock.
- At d=0, b=WW-1: oRdEn<=1, oAddr<=address counter, address counter increments.
  - When the address counter wraps from 2^ADDR_W-1 to 0 it is incremented and oSwitch toggles on that same clock.
  - Read latency must be <= BIT_DIV-2 clocks.
- At d=BIT_DIV-1, b=WW-1 (word boundary):
  - Counters advance: phrase wraps at PHR_PER_GRP-1 and carries to group; group wraps at GRP_PER_CCL-1 and carries to cycle; cycle wraps at CCL_PER_SEC-1 and carries to oSec.
  - oSec increments in BCD with per-digit 9->0 carry; 9999 wraps to 0000.
  - Word register <= encode(iData, iMode) | markers(new counters). iMode is sampled here only.
- Encoding: line bits [2i+1:2i] = {iData[i], iData[i]} for mode 0, {iData[i], ~iData[i]} for mode 1.
- Markers are OR'd into bits [WW-1:WW-2]:
  - Even phrase: bit WW-1 set.
  - Last group, phrase P-15, P-7, P-5 or P-1 (P = PHR_PER_GRP): both bits set.
  - Any other group, phrase P-13, P-11, P-9 or P-3: both bits set.
  - Cycle 0, group 0, phrase 15: both bits set.
- Enable:
  - If iEn=0 at a word boundary: counters, address and word register hold, and no read is issued.
  - oSerial is driven 0 from the next clock and no oValid/oRdEn/oFrameStart strobes occur.
  - The iData captured at that boundary (read issued while iEn was 1) is not loaded.
  - When iEn returns to 1 at a later boundary, transmission restarts at d=0, b=0 with the held word.
  - iEn changes mid-word are ignored.
- Width rules: all counters are sized to exactly cover their range. oSec digits never exceed 9.

Test Plan:
- Reset and first word: defaults, iEn=1, reset released -> oValid at the first d=0; oParallel=12'h800; oSerial=1 for 4 clks then 0 for the remaining 92 clks.
- Load and encoding: iData=12'hA5A, iMode=0, first read at addr 0 -> phrase 1 (odd, no marker) line word 24'hCC33CC with oParallel=12'hA5A. Same data with iMode=1 -> 24'h9966 99 pattern (pairs 10/01) with oParallel=12'hA5A.
- Markers: run to cycle 0/group 0/phrase 15 -> word MSBs 11. In group 31, phrase 127 -> MSBs 11; phrase 126 -> MSBs 10. In group 5, phrase 113 -> MSBs 00 (odd, not a marker phrase in a normal group).
- Address and bank: ADDR_W=3 -> oAddr sequence 0..7,0; oSwitch toggles exactly once, on the clock addr wraps to 0; oRdEn is exactly 1 clk wide per word.
- Seconds: PHR_PER_GRP=16, GRP_PER_CCL=1, CCL_PER_SEC=1, oSec preloaded via run to 0009 -> next tick gives 0010. Run to 9999 -> next tick gives 0000. oFrameStart pulses once per cycle.
- Enable and reset mid-word: iEn=0 over 3 word periods -> oSerial=0, no strobes, oAddr frozen; resume gives the next phrase number unchanged. Reset asserted at b=10 -> all outputs at reset values on the next clock; the sequence restarts identically to the first scenario.
